am_demod_ctrl: RTL and testbench

AM_DEMOD_CTRL -- requirements
Module: am_demod_ctrl

---
 rtl/am_demod_pkg.sv | 22 ++
 rtl/am_demod_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_am_demod_ctrl.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/am_demod_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : am_demod_pkg
//  Description : Shared types and constants for the AM demodulator control
//                block: FSM state encoding, default ratio field width and
//                the oversample ratio applied out of reset.
//  Revision    : 1.0 - initial release
// ============================================================================
package am_demod_pkg;

    localparam int c_DEFAULT_RATIO_WIDTH = 8;
    localparam int c_RESET_RATIO         = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FLUSH  = 2'd1,
        S_SETTLE = 2'd2,
        S_RUN    = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/am_demod_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : am_demod_ctrl
//  Description : Sequences an AM demodulator through reconfiguration. A
//                config request loads shadow ratio/settle registers, holds
//                the demodulator in reset for FLUSH_CYCLES, discards
//                cfg_settle_samples output strobes, then forwards samples
//                downstream with one cycle of latency while locked.
//  Ports       : clk, reset (sync, active high), enable (run/park level)
//                cfg_valid/cfg_ready/cfg_oversample_ratio/cfg_settle_samples
//                  - configuration handshake
//                demod_reset, demod_oversample_ratio - demodulator control
//                demod_out, demod_out_valid           - demodulator samples
//                out, out_valid                       - gated samples
//                locked, state, cfg_err               - status
//  Revision    : 1.0 - initial release
// ============================================================================
module am_demod_ctrl
    import am_demod_pkg::*;
#(
    parameter int OUTPUT_WIDTH = 16,
    parameter int RATIO_WIDTH  = c_DEFAULT_RATIO_WIDTH,
    parameter int FLUSH_CYCLES = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic                           cfg_valid,
    output logic                           cfg_ready,
    input  logic        [RATIO_WIDTH-1:0]  cfg_oversample_ratio,
    input  logic        [15:0]             cfg_settle_samples,
    output logic                           demod_reset,
    output logic        [RATIO_WIDTH-1:0]  demod_oversample_ratio,
    input  logic signed [OUTPUT_WIDTH-1:0] demod_out,
    input  logic                           demod_out_valid,
    output logic signed [OUTPUT_WIDTH-1:0] out,
    output logic                           out_valid,
    output logic                           locked,
    output logic        [1:0]              state,
    output logic                           cfg_err
);

    localparam int                c_FCNT_W     = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [c_FCNT_W-1:0] c_FLUSH_LAST = c_FCNT_W'(FLUSH_CYCLES - 1);

    state_t                          r_state;
    state_t                          w_state_next;
    logic        [c_FCNT_W-1:0]      r_flush_cnt;
    logic        [15:0]              r_settle_cnt;
    logic        [RATIO_WIDTH-1:0]   r_ratio;
    logic        [15:0]              r_settle_target;
    logic                            r_loaded;
    logic                            r_cfg_err;
    logic signed [OUTPUT_WIDTH-1:0]  r_out;
    logic                            r_out_valid;

    logic w_cfg_accept;
    logic w_cfg_load;
    logic w_cfg_reject;
    logic w_settle_hit;
    logic w_forward;

    // Config is only accepted while the demodulator is idle or running;
    // FLUSH and SETTLE must run to completion with a stable shadow set.
    assign cfg_ready    = (r_state == S_IDLE) || (r_state == S_RUN);
    assign w_cfg_accept = cfg_valid && cfg_ready;
    assign w_cfg_reject = w_cfg_accept && (cfg_oversample_ratio == '0);
    assign w_cfg_load   = w_cfg_accept && (cfg_oversample_ratio != '0);

    // The target is at least 1 whenever SETTLE is entered, so this matches
    // exactly the strobe that completes the discard window.
    assign w_settle_hit = demod_out_valid && ((r_settle_cnt + 16'd1) == r_settle_target);

    // Only strobes seen while already in RUN are passed on; the strobe that
    // completes SETTLE (the transition into RUN) is part of the discard set.
    assign w_forward    = (r_state == S_RUN) && demod_out_valid;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        demod_reset  = 1'b1;
        locked       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_loaded || w_cfg_load) begin
                    w_state_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (r_flush_cnt == c_FLUSH_LAST) begin
                    w_state_next = (r_settle_target == 16'd0) ? S_RUN : S_SETTLE;
                end
            end
            S_SETTLE: begin
                demod_reset = 1'b0;
                if (w_settle_hit) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                demod_reset = 1'b0;
                locked      = 1'b1;
                if (w_cfg_load) begin
                    w_state_next = S_FLUSH;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        // Dropping enable parks the block regardless of any config event.
        if (!enable) begin
            w_state_next = S_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Flush and settle counters; both restart whenever their state is left,
    // so RUN -> FLUSH naturally begins a fresh flush window.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flush_cnt  <= '0;
            r_settle_cnt <= '0;
        end else begin
            if (r_state == S_FLUSH) begin
                r_flush_cnt <= r_flush_cnt + c_FCNT_W'(1);
            end else begin
                r_flush_cnt <= '0;
            end

            if (r_state != S_SETTLE) begin
                r_settle_cnt <= '0;
            end else if (demod_out_valid && (r_settle_cnt != 16'hFFFF)) begin
                r_settle_cnt <= r_settle_cnt + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Shadow configuration and sticky error
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ratio         <= RATIO_WIDTH'(c_RESET_RATIO);
            r_settle_target <= '0;
            r_loaded        <= 1'b0;
            r_cfg_err       <= 1'b0;
        end else begin
            if (w_cfg_reject) begin
                r_cfg_err <= 1'b1;
            end
            if (w_cfg_load) begin
                r_ratio         <= cfg_oversample_ratio;
                r_settle_target <= cfg_settle_samples;
                r_loaded        <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output sample register; holds the last forwarded value
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_forward;
            if (w_forward) begin
                r_out <= demod_out;
            end
        end
    end

    assign state                  = r_state;
    assign demod_oversample_ratio = r_ratio;
    assign cfg_err                = r_cfg_err;
    assign out                    = r_out;
    assign out_valid              = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_am_demod_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_am_demod_ctrl
//  Description : Self-checking bench for am_demod_ctrl. A directed vector
//                table walks the main reconfiguration scenarios, a short
//                hand-written sequence covers reset aborts and a bounded
//                lock wait, and a random phase is compared cycle by cycle
//                against a countdown-style reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_am_demod_ctrl;

    localparam int OW = 16;
    localparam int RW = 8;
    localparam int FC = 16;

    // Reference model state codes
    localparam int M_IDLE = 0, M_FLUSH = 1, M_SETTLE = 2, M_RUN = 3;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 enable = 1'b0;
    logic                 cfg_valid = 1'b0;
    logic                 cfg_ready;
    logic [RW-1:0]        cfg_oversample_ratio = '0;
    logic [15:0]          cfg_settle_samples = '0;
    logic                 demod_reset;
    logic [RW-1:0]        demod_oversample_ratio;
    logic signed [OW-1:0] demod_out = '0;
    logic                 demod_out_valid = 1'b0;
    logic signed [OW-1:0] out;
    logic                 out_valid;
    logic                 locked;
    logic [1:0]           state;
    logic                 cfg_err;

    int errors = 0;
    int checks = 0;

    am_demod_ctrl #(
        .OUTPUT_WIDTH (OW),
        .RATIO_WIDTH  (RW),
        .FLUSH_CYCLES (FC)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .enable                 (enable),
        .cfg_valid              (cfg_valid),
        .cfg_ready              (cfg_ready),
        .cfg_oversample_ratio   (cfg_oversample_ratio),
        .cfg_settle_samples     (cfg_settle_samples),
        .demod_reset            (demod_reset),
        .demod_oversample_ratio (demod_oversample_ratio),
        .demod_out              (demod_out),
        .demod_out_valid        (demod_out_valid),
        .out                    (out),
        .out_valid              (out_valid),
        .locked                 (locked),
        .state                  (state),
        .cfg_err                (cfg_err)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: phases tracked as "cycles left" countdowns
    // ------------------------------------------------------------------
    int          m_state;
    int          m_flush_left;
    int          m_settle_left;
    int          m_ratio;
    int          m_settle;
    bit          m_loaded;
    bit          m_err;
    bit          m_ov;
    logic [15:0] m_out;

    task automatic model_step();
        bit ready, accept, load;
        int nxt;
        if (reset) begin
            m_state = M_IDLE; m_flush_left = 0; m_settle_left = 0;
            m_ratio = 8; m_settle = 0; m_loaded = 0; m_err = 0;
            m_ov = 0; m_out = 16'h0;
            return;
        end
        ready  = (m_state == M_IDLE) || (m_state == M_RUN);
        accept = cfg_valid && ready;
        load   = accept && (cfg_oversample_ratio != 0);
        if (accept && cfg_oversample_ratio == 0) m_err = 1;
        m_ov = (m_state == M_RUN) && demod_out_valid;
        if (m_ov) m_out = demod_out;
        nxt = m_state;
        case (m_state)
            M_IDLE: if (m_loaded || load) begin
                nxt = M_FLUSH; m_flush_left = FC;
            end
            M_FLUSH: begin
                m_flush_left--;
                if (m_flush_left == 0) begin
                    m_settle_left = m_settle;
                    nxt = (m_settle == 0) ? M_RUN : M_SETTLE;
                end
            end
            M_SETTLE: if (demod_out_valid) begin
                m_settle_left--;
                if (m_settle_left == 0) nxt = M_RUN;
            end
            default: if (load) begin
                nxt = M_FLUSH; m_flush_left = FC;
            end
        endcase
        if (!enable) nxt = M_IDLE;
        if (load) begin
            m_ratio  = int'(cfg_oversample_ratio);
            m_settle = int'(cfg_settle_samples);
            m_loaded = 1;
        end
        m_state = nxt;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("model_state",  {30'b0, state},                  32'(m_state));
        chk("model_drst",   {31'b0, demod_reset},            {31'b0, (m_state == M_IDLE) || (m_state == M_FLUSH)});
        chk("model_ready",  {31'b0, cfg_ready},              {31'b0, (m_state == M_IDLE) || (m_state == M_RUN)});
        chk("model_locked", {31'b0, locked},                 {31'b0, m_state == M_RUN});
        chk("model_ov",     {31'b0, out_valid},              {31'b0, m_ov});
        chk("model_out",    {16'b0, out},                    {16'b0, m_out});
        chk("model_ratio",  {24'b0, demod_oversample_ratio}, 32'(m_ratio));
        chk("model_err",    {31'b0, cfg_err},                {31'b0, m_err});
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_model();
    endtask

    // ------------------------------------------------------------------
    // Directed vector table: inputs held for 'rep' cycles, then checked
    // ------------------------------------------------------------------
    typedef struct {
        int rep; bit rst; bit en; bit cv; int cr; int cs; bit dv; int dout;
        int st; bit drst; bit rdy; bit lck; bit ov; int outv; int ratio; bit err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int rep, bit rst, bit en, bit cv, int cr, int cs, bit dv, int dout,
                                int st, bit drst, bit rdy, bit lck, bit ov, int outv, int ratio, bit err);
        vec_t v;
        v.rep = rep; v.rst = rst; v.en = en; v.cv = cv; v.cr = cr; v.cs = cs; v.dv = dv; v.dout = dout;
        v.st = st; v.drst = drst; v.rdy = rdy; v.lck = lck; v.ov = ov; v.outv = outv; v.ratio = ratio; v.err = err;
        return v;
    endfunction

    initial begin
        //            rep rs en cv cr cs dv dout      st dr rd lk ov out     rat er
        // reset, then ratio 8 / settle 4 bring-up
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0,       0, 1, 1, 0, 0, 0,      8, 0));
        tbl.push_back(mk(1, 0, 1, 1, 8, 4, 0, 0,       1, 1, 0, 0, 0, 0,      8, 0));
        tbl.push_back(mk(15,0, 1, 0, 0, 0, 0, 0,       1, 1, 0, 0, 0, 0,      8, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0,       2, 0, 0, 0, 0, 0,      8, 0));
        tbl.push_back(mk(3, 0, 1, 0, 0, 0, 1, 'h1111,  2, 0, 0, 0, 0, 0,      8, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 1, 'h2222,  3, 0, 1, 1, 0, 0,      8, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0,       3, 0, 1, 1, 0, 0,      8, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 1, 'h5555,  3, 0, 1, 1, 1, 'h5555, 8, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0,       3, 0, 1, 1, 0, 'h5555, 8, 0));
        // ratio 0 rejected in RUN
        tbl.push_back(mk(1, 0, 1, 1, 0, 7, 0, 0,       3, 0, 1, 1, 0, 'h5555, 8, 1));
        // ratio 4 / settle 2 reconfiguration from RUN; request held during FLUSH is ignored
        tbl.push_back(mk(1, 0, 1, 1, 4, 2, 0, 0,       1, 1, 0, 0, 0, 'h5555, 4, 1));
        tbl.push_back(mk(15,0, 1, 1, 9, 1, 0, 0,       1, 1, 0, 0, 0, 'h5555, 4, 1));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0,       2, 0, 0, 0, 0, 'h5555, 4, 1));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 1, 'h7777,  2, 0, 0, 0, 0, 'h5555, 4, 1));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 1, 'h7777,  3, 0, 1, 1, 0, 'h5555, 4, 1));
        // settle 0: FLUSH straight to RUN
        tbl.push_back(mk(1, 0, 1, 1, 3, 0, 0, 0,       1, 1, 0, 0, 0, 'h5555, 3, 1));
        tbl.push_back(mk(15,0, 1, 0, 0, 0, 0, 0,       1, 1, 0, 0, 0, 'h5555, 3, 1));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0,       3, 0, 1, 1, 0, 'h5555, 3, 1));
        // enable drop with simultaneous accepted config: IDLE, config still loads
        tbl.push_back(mk(1, 0, 0, 1, 6, 3, 0, 0,       0, 1, 1, 0, 0, 'h5555, 6, 1));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0,       1, 1, 0, 0, 0, 'h5555, 6, 1));
        tbl.push_back(mk(15,0, 1, 0, 0, 0, 0, 0,       1, 1, 0, 0, 0, 'h5555, 6, 1));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0,       2, 0, 0, 0, 0, 'h5555, 6, 1));
        // enable drop during SETTLE
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 'hAAAA,  0, 1, 1, 0, 0, 'h5555, 6, 1));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0,       1, 1, 0, 0, 0, 'h5555, 6, 1));
        tbl.push_back(mk(15,0, 1, 0, 0, 0, 0, 0,       1, 1, 0, 0, 0, 'h5555, 6, 1));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0,       2, 0, 0, 0, 0, 'h5555, 6, 1));
        tbl.push_back(mk(3, 0, 1, 0, 0, 0, 1, 'h1357,  3, 0, 1, 1, 0, 'h5555, 6, 1));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0,       3, 0, 1, 1, 0, 'h5555, 6, 1));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 1, 'h8001,  3, 0, 1, 1, 1, 'h8001, 6, 1));
        // reset pulse mid-RUN; config-loaded flag cleared so IDLE holds
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 1, 'h4444,  0, 1, 1, 0, 0, 0,      8, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0,       0, 1, 1, 0, 0, 0,      8, 0));
    end

    initial begin
        int waited;
        bit got_lock;
        #2;
        foreach (tbl[i]) begin
            reset                = tbl[i].rst;
            enable               = tbl[i].en;
            cfg_valid            = tbl[i].cv;
            cfg_oversample_ratio = RW'(tbl[i].cr);
            cfg_settle_samples   = 16'(tbl[i].cs);
            demod_out_valid      = tbl[i].dv;
            demod_out            = OW'(tbl[i].dout);
            repeat (tbl[i].rep) tick();
            chk($sformatf("vec%0d_state", i),  {30'b0, state},                  32'(tbl[i].st));
            chk($sformatf("vec%0d_drst", i),   {31'b0, demod_reset},            {31'b0, tbl[i].drst});
            chk($sformatf("vec%0d_ready", i),  {31'b0, cfg_ready},              {31'b0, tbl[i].rdy});
            chk($sformatf("vec%0d_locked", i), {31'b0, locked},                 {31'b0, tbl[i].lck});
            chk($sformatf("vec%0d_ov", i),     {31'b0, out_valid},              {31'b0, tbl[i].ov});
            chk($sformatf("vec%0d_out", i),    {16'b0, out},                    32'(tbl[i].outv));
            chk($sformatf("vec%0d_ratio", i),  {24'b0, demod_oversample_ratio}, 32'(tbl[i].ratio));
            chk($sformatf("vec%0d_err", i),    {31'b0, cfg_err},                {31'b0, tbl[i].err});
        end

        // Reset asserted mid-FLUSH aborts to IDLE with the reset ratio
        reset = 0; enable = 1; cfg_valid = 1; cfg_oversample_ratio = 8'd5;
        cfg_settle_samples = 16'd2; demod_out_valid = 0;
        tick();
        cfg_valid = 0;
        repeat (5) tick();
        chk("midflush_state", {30'b0, state}, 32'd1);
        reset = 1;
        tick();
        chk("midflush_abort_state", {30'b0, state}, 32'd0);
        chk("midflush_abort_ratio", {24'b0, demod_oversample_ratio}, 32'd8);

        // Bounded wait for lock with sparse strobes (settle 2)
        reset = 0; cfg_valid = 1; cfg_oversample_ratio = 8'd12; cfg_settle_samples = 16'd2;
        tick();
        cfg_valid = 0;
        got_lock = 0;
        waited = 0;
        while (!got_lock && waited < 80) begin
            demod_out_valid = (waited % 3 == 0);
            demod_out = OW'(waited);
            tick();
            got_lock = locked;
            waited++;
        end
        chk("lock_within_budget", {31'b0, got_lock}, 32'd1);
        chk("lock_ratio", {24'b0, demod_oversample_ratio}, 32'd12);

        // Randomized phase against the reference model
        for (int n = 0; n < 4000; n++) begin
            reset                = ($urandom_range(0, 299) == 0);
            enable               = ($urandom_range(0, 39) != 0);
            cfg_valid            = ($urandom_range(0, 15) == 0);
            cfg_oversample_ratio = ($urandom_range(0, 4) == 0) ? 8'd0 : RW'($urandom_range(1, 255));
            cfg_settle_samples   = 16'($urandom_range(0, 4));
            demod_out_valid      = $urandom_range(0, 1) == 1;
            demod_out            = OW'($urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
